hazard_forward_unit: RTL and testbench

- Parametrised successor to the two-operand forwarding mux-select logic.
- Sits between the decode and execute stages and serves NUM_SRC source operands.
- Compares decode-stage sources against in-flight destinations in EX, MEM and WB.
- Registers the bypass selects into the execute stage and runs a load-use stall FSM with configurable load latency and external freeze.

---
 rtl/hazard_forward_unit.sv | 117 +++++++++++
 tb/tb_hazard_forward_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - decode/execute operand bypass selects and load-use stall FSM
// Optional WB-cycle bypass (select 3) enabled by defining HAZARD_WB_BYPASS_EN.
module hazard_forward_unit #(
  parameter int AWIDTH      = 5,
  parameter int NUM_SRC     = 2,
  parameter int LOAD_LAT    = 1,
  parameter int ZERO_REG_EN = 1
) (
  input  logic                      d_clk,
  input  logic                      d_rst_n,
  input  logic                      ds_i_valid,
  input  logic [NUM_SRC*AWIDTH-1:0] ds_i_addr_rs,
  input  logic [NUM_SRC-1:0]        ds_i_use_rs,
  input  logic [AWIDTH-1:0]         es_i_addr_rd,
  input  logic                      es_i_regwrite,
  input  logic                      es_i_memread,
  input  logic [AWIDTH-1:0]         ms_i_addr_rd,
  input  logic                      ms_i_regwrite,
  input  logic [AWIDTH-1:0]         wb_i_addr_rd,
  input  logic                      wb_i_regwrite,
  input  logic                      ext_i_freeze,
  output logic [NUM_SRC*2-1:0]      f_o_control,
  output logic                      hz_o_stall,
  output logic                      hz_o_bubble
);

  typedef enum logic {ST_RUN, ST_STALL} state_e;

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  state_e                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [NUM_SRC*2-1:0]   ctrl_q, ctrl_d;
  logic [NUM_SRC*2-1:0]   sel_next;
  logic [NUM_SRC-1:0]     m_ex;
  logic                   load_use;

  genvar k;
  generate
    for (k = 0; k < NUM_SRC; k++) begin : g_src
      logic [AWIDTH-1:0] addr;
      logic              live;
      logic              m_ms;
      logic [1:0]        wb_sel;

      assign addr    = ds_i_addr_rs[k*AWIDTH +: AWIDTH];
      assign live    = ds_i_valid & ds_i_use_rs[k] & ~((ZERO_REG_EN != 0) && (addr == '0));
      assign m_ex[k] = live & es_i_regwrite & (addr == es_i_addr_rd);
      assign m_ms    = live & ms_i_regwrite & (addr == ms_i_addr_rd);
`ifdef HAZARD_WB_BYPASS_EN
      assign wb_sel  = (live & wb_i_regwrite & (addr == wb_i_addr_rd)) ? 2'd3 : 2'd0;
`else
      assign wb_sel  = 2'd0;
`endif
      assign sel_next[2*k +: 2] = m_ex[k] ? 2'd1 : (m_ms ? 2'd2 : wb_sel);
    end
  endgenerate

`ifndef HAZARD_WB_BYPASS_EN
  // Write-first register file makes the WB stage irrelevant here.
  logic unused_wb;
  assign unused_wb = ^{wb_i_addr_rd, wb_i_regwrite};
`endif

  // Detection is masked while already stalling; the consumer is re-evaluated on return.
  assign load_use = (state_q == ST_RUN) & es_i_memread & (|m_ex);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctrl_d      = ctrl_q;
    hz_o_stall  = 1'b0;
    hz_o_bubble = 1'b0;
    if (!ext_i_freeze) begin
      case (state_q)
        ST_RUN: begin
          if (load_use) begin
            hz_o_stall  = 1'b1;
            hz_o_bubble = 1'b1;
            ctrl_d      = '0;
            cnt_d       = LAT_M1;
            if (LAT_M1 != 3'd0) state_d = ST_STALL;
          end else begin
            ctrl_d = sel_next;
          end
        end
        ST_STALL: begin
          hz_o_stall  = 1'b1;
          hz_o_bubble = 1'b1;
          ctrl_d      = '0;
          if (cnt_q <= 3'd1) begin
            cnt_d   = 3'd0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge d_clk or negedge d_rst_n) begin
    if (!d_rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign f_o_control = ctrl_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed bench for hazard_forward_unit (LOAD_LAT 1 and 3 side by side)
module tb_hazard_forward_unit;

  logic       d_clk = 1'b0;
  logic       d_rst_n;
  logic       ds_i_valid;
  logic [9:0] ds_i_addr_rs;
  logic [1:0] ds_i_use_rs;
  logic [4:0] es_i_addr_rd, ms_i_addr_rd, wb_i_addr_rd;
  logic       es_i_regwrite, es_i_memread, ms_i_regwrite, wb_i_regwrite;
  logic       ext_i_freeze;
  logic [3:0] ctrl_a, ctrl_b;
  logic       stall_a, stall_b, bubble_a, bubble_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 d_clk = ~d_clk;

  hazard_forward_unit #(.AWIDTH(5), .NUM_SRC(2), .LOAD_LAT(1), .ZERO_REG_EN(1)) dut_a (
    .d_clk(d_clk), .d_rst_n(d_rst_n), .ds_i_valid(ds_i_valid), .ds_i_addr_rs(ds_i_addr_rs),
    .ds_i_use_rs(ds_i_use_rs), .es_i_addr_rd(es_i_addr_rd), .es_i_regwrite(es_i_regwrite),
    .es_i_memread(es_i_memread), .ms_i_addr_rd(ms_i_addr_rd), .ms_i_regwrite(ms_i_regwrite),
    .wb_i_addr_rd(wb_i_addr_rd), .wb_i_regwrite(wb_i_regwrite), .ext_i_freeze(ext_i_freeze),
    .f_o_control(ctrl_a), .hz_o_stall(stall_a), .hz_o_bubble(bubble_a));

  hazard_forward_unit #(.AWIDTH(5), .NUM_SRC(2), .LOAD_LAT(3), .ZERO_REG_EN(1)) dut_b (
    .d_clk(d_clk), .d_rst_n(d_rst_n), .ds_i_valid(ds_i_valid), .ds_i_addr_rs(ds_i_addr_rs),
    .ds_i_use_rs(ds_i_use_rs), .es_i_addr_rd(es_i_addr_rd), .es_i_regwrite(es_i_regwrite),
    .es_i_memread(es_i_memread), .ms_i_addr_rd(ms_i_addr_rd), .ms_i_regwrite(ms_i_regwrite),
    .wb_i_addr_rd(wb_i_addr_rd), .wb_i_regwrite(wb_i_regwrite), .ext_i_freeze(ext_i_freeze),
    .f_o_control(ctrl_b), .hz_o_stall(stall_b), .hz_o_bubble(bubble_b));

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining forced-stall cycles after the hazard cycle, per instance.
  int         rem   [2];
  logic [3:0] ectrl [2];

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [1:0] model_sel(input logic [4:0] rs, input logic used);
    if (!ds_i_valid || !used || rs == 5'd0) return 2'd0;
    if (es_i_regwrite && rs == es_i_addr_rd) return 2'd1;
    if (ms_i_regwrite && rs == ms_i_addr_rd) return 2'd2;
`ifdef HAZARD_WB_BYPASS_EN
    if (wb_i_regwrite && rs == wb_i_addr_rd) return 2'd3;
`endif
    return 2'd0;
  endfunction

  function automatic logic model_hazard();
    return es_i_memread && (model_sel(ds_i_addr_rs[4:0], ds_i_use_rs[0]) == 2'd1 ||
                            model_sel(ds_i_addr_rs[9:5], ds_i_use_rs[1]) == 2'd1);
  endfunction

  function automatic logic model_stall(input int i);
    return !ext_i_freeze && (rem[i] > 0 || model_hazard());
  endfunction

  always @(posedge d_clk or negedge d_rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!d_rst_n) begin
        rem[i]   <= 0;
        ectrl[i] <= 4'd0;
      end else if (!ext_i_freeze) begin
        if (rem[i] > 0) begin
          rem[i]   <= rem[i] - 1;
          ectrl[i] <= 4'd0;
        end else if (model_hazard()) begin
          rem[i]   <= lat(i) - 1;
          ectrl[i] <= 4'd0;
        end else begin
          ectrl[i] <= {model_sel(ds_i_addr_rs[9:5], ds_i_use_rs[1]),
                       model_sel(ds_i_addr_rs[4:0], ds_i_use_rs[0])};
        end
      end
    end
  end

  always @(negedge d_clk) begin
    check("model_ctrl_a",   ctrl_a,   ectrl[0]);
    check("model_ctrl_b",   ctrl_b,   ectrl[1]);
    check("model_stall_a",  stall_a,  model_stall(0));
    check("model_stall_b",  stall_b,  model_stall(1));
    check("model_bubble_a", bubble_a, model_stall(0));
    check("model_bubble_b", bubble_b, model_stall(1));
  end

  task automatic set_in(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [1:0] use_rs, input logic [4:0] exrd, input logic exw,
                        input logic exm, input logic [4:0] msrd, input logic msw,
                        input logic [4:0] wbrd, input logic wbw, input logic frz);
    ds_i_valid    = v;
    ds_i_addr_rs  = {rs2, rs1};
    ds_i_use_rs   = use_rs;
    es_i_addr_rd  = exrd;
    es_i_regwrite = exw;
    es_i_memread  = exm;
    ms_i_addr_rd  = msrd;
    ms_i_regwrite = msw;
    wb_i_addr_rd  = wbrd;
    wb_i_regwrite = wbw;
    ext_i_freeze  = frz;
  endtask

  task automatic tick();
    @(posedge d_clk);
    #1;
  endtask

  initial begin
    d_rst_n = 1'b0;
    set_in(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    check("reset_ctrl_a", ctrl_a, 0);
    check("reset_ctrl_b", ctrl_b, 0);
    check("reset_stall_a", stall_a, 0);
    check("reset_bubble_b", bubble_b, 0);
    d_rst_n = 1'b1;

    set_in(1, 3, 0, 2'b11, 3, 1, 0, 0, 0, 0, 0, 0);
    #1 check("ex_fwd_nostall", stall_a, 0);
    tick();
    check("ex_fwd_a", ctrl_a, 4'b0001);
    check("ex_fwd_b", ctrl_b, 4'b0001);

    set_in(1, 5, 7, 2'b11, 7, 1, 0, 7, 1, 0, 0, 0);
    tick();
    check("ex_over_mem", ctrl_a, 4'b0100);

    set_in(1, 0, 0, 2'b11, 0, 1, 0, 0, 1, 0, 0, 0);
    tick();
    check("zero_reg", ctrl_a, 4'b0000);

    set_in(1, 6, 6, 2'b01, 1, 1, 0, 6, 1, 0, 0, 0);
    tick();
    check("mem_fwd_use_mask", ctrl_a, 4'b0010);

    set_in(0, 6, 6, 2'b01, 1, 1, 0, 6, 1, 0, 0, 0);
    tick();
    check("invalid_decode", ctrl_a, 4'b0000);

    set_in(1, 9, 2, 2'b11, 1, 1, 0, 2, 1, 9, 1, 0);
    tick();
`ifdef HAZARD_WB_BYPASS_EN
    check("wb_bypass", ctrl_a, 4'b1011);
`else
    check("wb_bypass", ctrl_a, 4'b1000);
`endif

    // Load-use, LOAD_LAT=1 against LOAD_LAT=3
    set_in(1, 4, 8, 2'b01, 4, 1, 1, 0, 0, 0, 0, 0);
    #1;
    check("lu_stall_a", stall_a, 1);
    check("lu_bubble_a", bubble_a, 1);
    check("lu_stall_b", stall_b, 1);
    tick();
    check("lu_bubble_ctrl_a", ctrl_a, 4'b0000);
    set_in(1, 4, 8, 2'b01, 0, 0, 0, 4, 1, 0, 0, 0);
    #1;
    check("lu_release_a", stall_a, 0);
    check("lu_hold_b", stall_b, 1);
    tick();
    check("lu_load_in_mem_a", ctrl_a, 4'b0010);
    check("lu_still_bubble_b", ctrl_b, 4'b0000);
    set_in(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    // Freeze for two cycles in the middle of a LOAD_LAT=3 stall
    set_in(1, 4, 8, 2'b01, 4, 1, 1, 0, 0, 0, 0, 0);
    #1 check("fz_c0_stall_b", stall_b, 1);
    tick();
    set_in(1, 4, 8, 2'b01, 0, 0, 0, 4, 1, 0, 0, 0);
    #1 check("fz_c1_stall_b", stall_b, 1);
    tick();
    check("fz_c1_ctrl_a", ctrl_a, 4'b0010);
    set_in(1, 4, 8, 2'b01, 4, 1, 0, 0, 0, 0, 0, 1);
    #1;
    check("fz_stall_b_masked", stall_b, 0);
    check("fz_bubble_b_masked", bubble_b, 0);
    check("fz_stall_a_masked", stall_a, 0);
    tick();
    check("fz_ctrl_a_hold", ctrl_a, 4'b0010);
    tick();
    ext_i_freeze = 1'b0;
    #1;
    check("fz_resume_stall_b", stall_b, 1);
    check("fz_resume_stall_a", stall_a, 0);
    tick();
    check("fz_resume_ctrl_a", ctrl_a, 4'b0001);
    check("fz_resume_ctrl_b", ctrl_b, 4'b0000);
    #1 check("fz_done_stall_b", stall_b, 0);
    tick();
    check("fz_done_ctrl_b", ctrl_b, 4'b0001);

    // Asynchronous reset while dut_b is in its stall state
    set_in(1, 4, 8, 2'b01, 4, 1, 1, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 4, 8, 2'b01, 0, 0, 0, 4, 1, 0, 0, 0);
    tick();
    check("rst_pre_stall_b", stall_b, 1);
    check("rst_pre_ctrl_a", ctrl_a, 4'b0010);
    d_rst_n = 1'b0;
    #1;
    check("rst_async_ctrl_a", ctrl_a, 0);
    check("rst_async_stall_b", stall_b, 0);
    check("rst_async_bubble_b", bubble_b, 0);
    tick();
    d_rst_n = 1'b1;
    set_in(1, 4, 8, 2'b01, 4, 1, 1, 0, 0, 0, 0, 0);
    #1;
    check("rst_after_stall_a", stall_a, 1);
    check("rst_after_stall_b", stall_b, 1);
    tick();
    set_in(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
